// File: rtl/sym_dn_lut_out_mp.sv
// rtl/sym_dn_lut_out_mp.sv - multi-port symmetric decision-node LUT reader with serial loader
module sym_dn_lut_out_mp #(
   parameter  int QUAN_SIZE       = 3,
   parameter  int PORT_NUM        = 4,
   parameter  int MULTI_FRAME_NUM = 2,
   localparam int FRM_W           = $clog2(MULTI_FRAME_NUM),
   localparam int PAGE_W          = 2*QUAN_SIZE-1,
   localparam int PAGE_DEPTH      = 2**PAGE_W,
   localparam int ADDR_W          = FRM_W + PAGE_W
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          in_valid,
   input  logic [PORT_NUM-1:0]           transpose_en_in,
   input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
   input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
   input  logic [FRM_W-1:0]              read_frame_sel,
   output logic                          out_valid,
   output logic [PORT_NUM-1:0]           t_c,
   input  logic                          lut_load_start,
   input  logic [FRM_W-1:0]              lut_load_frame,
   input  logic                          lut_load_valid,
   input  logic                          lut_load_bit,
   output logic                          lut_busy,
   output logic                          lut_load_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

   localparam logic [PAGE_W-1:0] LAST_ENTRY = PAGE_W'(PAGE_DEPTH-1);

   // Hard-decision LUT storage, all frames back to back; contents survive reset.
   logic lut [MULTI_FRAME_NUM*PAGE_DEPTH];

   logic [ADDR_W-1:0]   addr_d [PORT_NUM];
   logic [PORT_NUM-1:0] msb_d;

   logic [ADDR_W-1:0]   addr_q [PORT_NUM];
   logic [PORT_NUM-1:0] msb0_q;
   logic                valid0_q;
   logic [PORT_NUM-1:0] lut_q;
   logic [PORT_NUM-1:0] msb1_q;
   logic                valid1_q;

   state_t            state_q, state_d;
   logic [PAGE_W-1:0] cnt_q, cnt_d;
   logic [FRM_W-1:0]  frame_q, frame_d;
   logic              we;

   // Fold each port's message onto the positive half of the table using the sign bit.
   for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
      logic [QUAN_SIZE-1:0] y0, y1, y1m;
      logic [QUAN_SIZE-2:0] y0m;
      assign y0       = y0_in[p*QUAN_SIZE +: QUAN_SIZE];
      assign y1       = y1_in[p*QUAN_SIZE +: QUAN_SIZE];
      assign msb_d[p] = transpose_en_in[p] ^ y0[QUAN_SIZE-1];
      assign y0m      = y0[QUAN_SIZE-2:0] ^ {(QUAN_SIZE-1){y0[QUAN_SIZE-1]}};
      assign y1m      = msb_d[p] ? ~y1 : y1;
      assign addr_d[p] = {read_frame_sel, y0m, y1m};
   end

   // Stage 0 captures addresses, stage 1 samples the LUT; both advance every cycle.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int p = 0; p < PORT_NUM; p++) addr_q[p] <= '0;
         msb0_q   <= '0;
         valid0_q <= 1'b0;
         lut_q    <= '0;
         msb1_q   <= '0;
         valid1_q <= 1'b0;
      end else begin
         for (int p = 0; p < PORT_NUM; p++) begin
            addr_q[p] <= addr_d[p];
            lut_q[p]  <= lut[addr_q[p]];
         end
         msb0_q   <= msb_d;
         valid0_q <= in_valid;
         msb1_q   <= msb0_q;
         valid1_q <= valid0_q;
      end
   end

   assign t_c       = lut_q ^ msb1_q;
   assign out_valid = valid1_q;

   // Loader state register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
      end
   end

   // Loader next state: auto-incrementing serial write, one-cycle done on the last entry.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      frame_d       = frame_q;
      we            = 1'b0;
      lut_busy      = 1'b0;
      lut_load_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (lut_load_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               frame_d = lut_load_frame;
            end
         end
         ST_LOAD: begin
            lut_busy = 1'b1;
            if (lut_load_valid) begin
               we    = 1'b1;
               cnt_d = cnt_q + PAGE_W'(1);
               if (cnt_q == LAST_ENTRY) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            lut_load_done = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // LUT write port; a same-edge read still sees the previous value.
   always_ff @(posedge sys_clk) begin
      if (we && !sys_rst) lut[{frame_q, cnt_q}] <= lut_load_bit;
   end

endmodule

// File: tb/tb_sym_dn_lut_out_mp.sv
// tb/tb_sym_dn_lut_out_mp.sv - directed bench for sym_dn_lut_out_mp
module tb_sym_dn_lut_out_mp;

   localparam int Q  = 3;
   localparam int PN = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          in_valid;
   logic [PN-1:0] transpose_en_in;
   logic [PN*Q-1:0] y0_in, y1_in;
   logic          read_frame_sel;
   logic          out_valid;
   logic [PN-1:0] t_c;
   logic          lut_load_start, lut_load_frame, lut_load_valid, lut_load_bit;
   logic          lut_busy, lut_load_done;

   int total = 0;
   int bad   = 0;
   logic ref_lut [64];

   sym_dn_lut_out_mp #(.QUAN_SIZE(3), .PORT_NUM(4), .MULTI_FRAME_NUM(2)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid),
      .transpose_en_in(transpose_en_in), .y0_in(y0_in), .y1_in(y1_in),
      .read_frame_sel(read_frame_sel), .out_valid(out_valid), .t_c(t_c),
      .lut_load_start(lut_load_start), .lut_load_frame(lut_load_frame),
      .lut_load_valid(lut_load_valid), .lut_load_bit(lut_load_bit),
      .lut_busy(lut_busy), .lut_load_done(lut_load_done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic model(input logic fr, input logic [2:0] y0, input logic [2:0] y1,
                                  input logic tr);
      logic       msb;
      logic [1:0] m0;
      logic [2:0] m1;
      msb = tr ^ y0[2];
      m0  = {y0[1] ^ y0[2], y0[0] ^ y0[2]};
      m1  = msb ? ~y1 : y1;
      return ref_lut[{fr, m0, m1}] ^ msb;
   endfunction

   task automatic load_frame(input logic fr, input logic [31:0] bits, input bit gaps,
                             input bit restart_mid);
      int done_cnt = 0;
      int busy_err = 0;
      int ng;
      lut_load_start = 1'b1;
      lut_load_frame = fr;
      tick();
      lut_load_start = 1'b0;
      chk("load_busy_start", lut_busy, 1);
      for (int i = 0; i < 32; i++) begin
         ng = gaps ? $urandom_range(0, 2) : 0;
         for (int g = 0; g < ng; g++) begin
            lut_load_valid = 1'b0;
            tick();
            if (lut_load_done) done_cnt++;
            if (!lut_busy) busy_err++;
         end
         lut_load_valid = 1'b1;
         lut_load_bit   = bits[i];
         if (restart_mid && i == 16) begin
            lut_load_start = 1'b1;
            lut_load_frame = ~fr;
         end
         tick();
         lut_load_start = 1'b0;
         lut_load_frame = fr;
         ref_lut[{fr, 5'(i)}] = bits[i];
         if (lut_load_done) done_cnt++;
         if (i < 31 && !lut_busy) busy_err++;
      end
      lut_load_valid = 1'b0;
      chk("load_done_after_last", lut_load_done, 1);
      chk("load_busy_after_last", lut_busy, 0);
      tick();
      if (lut_load_done) done_cnt++;
      chk("load_busy_gaps", busy_err, 0);
      chk("load_done_count", done_cnt, 1);
   endtask

   task automatic sweep(input logic fr, input int off);
      logic [PN-1:0] exp_q [$];
      logic [PN-1:0] e;
      logic [5:0]    v;
      int ov_cnt = 0;
      for (int i = 0; i < 34; i++) begin
         if (i < 32) begin
            in_valid       = 1'b1;
            read_frame_sel = fr;
            for (int p = 0; p < PN; p++) begin
               v = 6'((i*9 + p*17 + off) % 64);
               y0_in[p*Q +: Q]    = v[5:3];
               y1_in[p*Q +: Q]    = v[2:0];
               transpose_en_in[p] = v[1] ^ v[4];
               e[p] = model(fr, v[5:3], v[2:0], v[1] ^ v[4]);
            end
            exp_q.push_back(e);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            chk("sweep_valid", out_valid, (i <= 32) ? 1 : 0);
            if (out_valid) ov_cnt++;
            if (i <= 32) chk("sweep_tc", t_c, exp_q.pop_front());
         end
      end
      chk("sweep_valid_count", ov_cnt, 32);
   endtask

   task automatic read_one(input logic [PN-1:0] tr, input logic [PN*Q-1:0] y0,
                           input logic [PN*Q-1:0] y1, input string tag,
                           input logic [PN-1:0] exp);
      in_valid = 1'b1; read_frame_sel = 1'b1;
      transpose_en_in = tr; y0_in = y0; y1_in = y1;
      tick();
      in_valid = 1'b0;
      tick();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_tc"}, t_c, exp);
   endtask

   initial begin
      sys_rst = 1'b1; in_valid = 1'b1; transpose_en_in = '0; y0_in = '0; y1_in = '0;
      read_frame_sel = 1'b0; lut_load_start = 1'b0; lut_load_frame = 1'b0;
      lut_load_valid = 1'b0; lut_load_bit = 1'b0;
      for (int i = 0; i < 64; i++) ref_lut[i] = 1'b0;

      // reset with in_valid held high
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_out_valid", out_valid, 0);
         chk("rst_tc", t_c, 0);
         chk("rst_busy", lut_busy, 0);
         chk("rst_done", lut_load_done, 0);
      end
      sys_rst = 1'b0; in_valid = 1'b0;
      tick();

      // frame 1: only entry 5 set
      load_frame(1'b1, 32'h0000_0020, 1'b0, 1'b0);
      // port0 y0=000 y1=101 -> entry 5 -> 1; others read entry 0 -> 0
      read_one(4'b0000, 12'b000_000_000_000, 12'b000_000_000_101, "port0_e5", 4'b0001);
      // port1 y0=100 y1=010 tr=0: msb=1, y0m=11, y1m=101 -> entry 29 -> 0^1=1
      read_one(4'b0000, 12'b000_000_100_000, 12'b000_000_010_101, "port1_tr0", 4'b0011);
      // port1 tr=1: msb=0, y0m=11, y1m=010 -> entry 26 -> 0
      read_one(4'b0010, 12'b000_000_100_000, 12'b000_000_010_101, "port1_tr1", 4'b0001);

      // give frame 0 known content, then back-to-back sweeps
      load_frame(1'b0, 32'hA5C3_0F96, 1'b0, 1'b0);
      sweep(1'b1, 0);
      sweep(1'b0, 3);

      // gapped load of frame 1 with an ignored restart toward frame 0
      load_frame(1'b1, 32'h3C5A_96E1, 1'b1, 1'b1);
      sweep(1'b0, 5);
      sweep(1'b1, 11);

      // reset drops an in-flight read
      in_valid = 1'b1; read_frame_sel = 1'b1;
      tick();
      in_valid = 1'b0; sys_rst = 1'b1;
      tick();
      chk("rst_drop_valid", out_valid, 0);
      sys_rst = 1'b0;
      tick();
      chk("rst_drop_valid2", out_valid, 0);

      // reset after 10 loaded bits
      lut_load_start = 1'b1; lut_load_frame = 1'b1;
      tick();
      lut_load_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         lut_load_valid = 1'b1;
         lut_load_bit   = ~ref_lut[{1'b1, 5'(i)}];
         ref_lut[{1'b1, 5'(i)}] = lut_load_bit;
         tick();
      end
      lut_load_valid = 1'b0; sys_rst = 1'b1;
      tick();
      chk("midrst_busy", lut_busy, 0);
      chk("midrst_done", lut_load_done, 0);
      sys_rst = 1'b0;
      tick();
      chk("midrst_busy2", lut_busy, 0);
      chk("midrst_done2", lut_load_done, 0);
      sweep(1'b1, 1);
      load_frame(1'b1, 32'h6B1D_F04E, 1'b1, 1'b0);
      sweep(1'b1, 7);
      sweep(1'b0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
